// File: rtl/load_store_unit.sv
// Load/store stage: runs one access per MemReq on a valid/ready bus, stalls the core
// until completion, and reports misaligned, illegal-funct3 and bus-timeout errors.
module load_store_unit #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReq,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic        Stall,
   output logic        Done,
   output logic [31:0] ReadData,
   output logic        Err,
   output logic [1:0]  ErrCode,
   output logic        MemValid,
   input  logic        MemReady,
   output logic [31:0] MemAddr,
   output logic        MemWe,
   output logic [3:0]  MemWStrb,
   output logic [31:0] MemWData,
   input  logic [31:0] MemRData
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  f3_q, f3_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [1:0]  err_code_q, err_code_d;
   logic        mem_valid_q, mem_valid_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        mem_we_q, mem_we_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] read_data_q, read_data_d;
   logic        illegal_s;
   logic        misaligned_s;
   logic        timeout_hit_s;

   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(word >> {off, 3'b000});
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'd0, b};
         3'b101:  return {16'd0, h};
         default: return word;
      endcase
   endfunction

   function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   return 4'b0001 << off;
         2'b01:   return off[1] ? 4'b1100 : 4'b0011;
         2'b10:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
      case (f3[1:0])
         2'b00:   return {4{wd[7:0]}};
         2'b01:   return {2{wd[15:0]}};
         2'b10:   return wd;
         default: return 32'd0;
      endcase
   endfunction

   // Legality of the incoming request: funct3 decode first, then alignment
   always_comb begin
      case (Funct3)
         3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
         3'b100, 3'b101:         illegal_s = MemWrite;
         default:                illegal_s = 1'b1;
      endcase
      case (Funct3[1:0])
         2'b01:   misaligned_s = ALUResult[0];
         2'b10:   misaligned_s = |ALUResult[1:0];
         default: misaligned_s = 1'b0;
      endcase
   end

   assign timeout_hit_s = (TIMEOUT != 0) && ((cnt_q + 32'd1) == 32'(TIMEOUT));

   // Next-state and registered-output computation
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      off_d       = off_q;
      f3_d        = f3_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      err_code_d  = 2'b00;
      mem_valid_d = mem_valid_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = mem_we_q;
      mem_wstrb_d = mem_wstrb_q;
      mem_wdata_d = mem_wdata_q;
      read_data_d = read_data_q;
      case (state_q)
         IDLE: begin
            if (MemReq) begin
               off_d = ALUResult[1:0];
               f3_d  = Funct3;
               if (illegal_s || misaligned_s) begin
                  state_d     = RESP;
                  done_d      = 1'b1;
                  err_d       = 1'b1;
                  err_code_d  = illegal_s ? 2'b11 : 2'b01;
                  read_data_d = 32'd0;
               end else begin
                  state_d     = BUSY;
                  cnt_d       = 32'd0;
                  mem_valid_d = 1'b1;
                  mem_addr_d  = {ALUResult[31:2], 2'b00};
                  mem_we_d    = MemWrite;
                  mem_wstrb_d = MemWrite ? store_strb(Funct3, ALUResult[1:0]) : 4'b0000;
                  mem_wdata_d = MemWrite ? store_lanes(Funct3, WriteData) : 32'd0;
               end
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (MemReady) begin
               state_d     = RESP;
               mem_valid_d = 1'b0;
               done_d      = 1'b1;
               read_data_d = mem_we_q ? 32'd0 : load_extend(f3_q, off_q, MemRData);
            end else if (timeout_hit_s) begin
               state_d     = RESP;
               mem_valid_d = 1'b0;
               done_d      = 1'b1;
               err_d       = 1'b1;
               err_code_d  = 2'b10;
               read_data_d = 32'd0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any in-flight transfer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 32'd0;
         off_q       <= 2'd0;
         f3_q        <= 3'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= 2'b00;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_we_q    <= 1'b0;
         mem_wstrb_q <= 4'b0000;
         mem_wdata_q <= 32'd0;
         read_data_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         off_q       <= off_d;
         f3_q        <= f3_d;
         done_q      <= done_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wstrb_q <= mem_wstrb_d;
         mem_wdata_q <= mem_wdata_d;
         read_data_q <= read_data_d;
      end
   end

   assign Stall    = ((state_q == IDLE) && MemReq) || (state_q == BUSY);
   assign Done     = done_q;
   assign Err      = err_q;
   assign ErrCode  = err_code_q;
   assign MemValid = mem_valid_q;
   assign MemAddr  = mem_addr_q;
   assign MemWe    = mem_we_q;
   assign MemWStrb = mem_wstrb_q;
   assign MemWData = mem_wdata_q;
   assign ReadData = read_data_q;

endmodule
